// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose
//   Exhaustive stimulus/checker for small combinational lab circuits. After a
//   start pulse it walks every input vector 0 .. 2^N_IN-1 onto the circuit
//   under test, waits SETTLE cycles for the circuit to settle, samples its
//   output f_in, and compares it against the EXPECT truth table. At the end of
//   the sweep it reports the mismatch count, the first failing vector index
//   and an overall pass flag.
//
// Parameters
//   N_IN    number of circuit inputs; vec[N_IN-1] drives a, vec[0] drives d
//   EXPECT  expected truth table, bit i = expected f for vec == i
//   SETTLE  wait cycles after driving a vector before sampling f (>= 1)
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        one-cycle pulse, begins a sweep when idle
//   f_in       in   1        output of the circuit under test
//   vec        out  N_IN     vector applied to the circuit inputs {a,b,c,d}
//   busy       out  1        high while a sweep is in progress
//   done       out  1        one-cycle pulse when a sweep ends
//   pass       out  1        valid from done until next start, 1 = no mismatch
//   err_count  out  N_IN+1   mismatches found in the last sweep
//   first_fail out  N_IN     index of the first mismatching vector, 0 if none
//
// Build option
//   SWEEP_STOP_ON_FAIL_EN  when defined, the sweep ends at the first mismatch:
//                          err_count = 1, first_fail = failing index, and vec
//                          keeps the failing vector after done so it can be
//                          probed on the board. When undefined, the whole
//                          table is always swept.
//
// Timing (default build): start to done = 2^N_IN*(SETTLE+2)+1 cycles, i.e.
// each vector costs SETTLE drive cycles + 1 sample cycle + 1 advance cycle.
// All outputs are registered.
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int                     N_IN   = 4,
  parameter logic [(1<<N_IN)-1:0]   EXPECT = 16'h0054,
  parameter int                     SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              f_in,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail
);

  // Settle counter only needs to reach SETTLE-1; keep it at least one bit.
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1'b1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_NEXT   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_s;
  logic [N_IN-1:0]   vec_r;
  logic [N_IN-1:0]   vec_s;
  logic              busy_r;
  logic              busy_s;
  logic              done_r;
  logic              done_s;
  logic              pass_r;
  logic              pass_s;
  logic [N_IN:0]     err_count_r;
  logic [N_IN:0]     err_count_s;
  logic [N_IN-1:0]   first_fail_r;
  logic [N_IN-1:0]   first_fail_s;
  logic              mismatch_s;
  logic              sweep_end_s;

  // Expected circuit output for a given table index.
  function automatic logic expect_bit(input logic [N_IN-1:0] idx);
    return EXPECT[idx];
  endfunction

  // Compare the sampled circuit output against the truth table.
  always_comb begin
    mismatch_s = f_in ^ expect_bit(vec_r);
  end

  // Decide in NEXT whether the sweep is over. The last vector always ends it;
  // vec is never advanced past the last index, so it cannot wrap.
  always_comb begin
    sweep_end_s = 1'b0;
    if (state_r == S_NEXT) begin
      if (vec_r == VEC_LAST) begin
        sweep_end_s = 1'b1;
      end else begin
`ifdef SWEEP_STOP_ON_FAIL_EN
        // A mismatch recorded in the preceding SAMPLE ends the sweep with vec
        // still pointing at the failing vector.
        sweep_end_s = (err_count_r != {(N_IN + 1){1'b0}});
`else
        sweep_end_s = 1'b0;
`endif
      end
    end else begin
      sweep_end_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so pulses during a
  // sweep or in the FIN cycle are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_DRIVE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_SAMPLE;
        end else begin
          state_s = S_DRIVE;
        end
      end
      S_SAMPLE: begin
        state_s = S_NEXT;
      end
      S_NEXT: begin
        if (sweep_end_s) begin
          state_s = S_FIN;
        end else begin
          state_s = S_DRIVE;
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and settle counter.
  // done/busy/pass are set on the transition into FIN so they are visible
  // during the FIN cycle itself.
  always_comb begin
    cnt_s        = cnt_r;
    vec_s        = vec_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    pass_s       = pass_r;
    err_count_s  = err_count_r;
    first_fail_s = first_fail_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          cnt_s        = {CW{1'b0}};
          vec_s        = {N_IN{1'b0}};
          busy_s       = 1'b1;
          pass_s       = 1'b0;
          err_count_s  = {(N_IN + 1){1'b0}};
          first_fail_s = {N_IN{1'b0}};
        end else begin
          cnt_s        = cnt_r;
        end
      end
      S_DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_SAMPLE: begin
        if (mismatch_s) begin
          err_count_s = err_count_r + ERR_ONE;
          if (err_count_r == {(N_IN + 1){1'b0}}) begin
            first_fail_s = vec_r;
          end else begin
            first_fail_s = first_fail_r;
          end
        end else begin
          err_count_s = err_count_r;
        end
      end
      S_NEXT: begin
        if (sweep_end_s) begin
          busy_s = 1'b0;
          done_s = 1'b1;
          pass_s = (err_count_r == {(N_IN + 1){1'b0}});
        end else begin
          vec_s  = vec_r + VEC_ONE;
        end
      end
      S_FIN: begin
        done_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and settle counter; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {CW{1'b0}};
      vec_r        <= {N_IN{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_count_r  <= {(N_IN + 1){1'b0}};
      first_fail_r <= {N_IN{1'b0}};
    end else begin
      cnt_r        <= cnt_s;
      vec_r        <= vec_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_count_r  <= err_count_s;
      first_fail_r <= first_fail_s;
    end
  end

  assign vec        = vec_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_count_r;
  assign first_fail = first_fail_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (default build, N_IN=4, SETTLE=2,
// EXPECT=16'h0054). A behavioural circuit under test produces f_in from vec
// in one of several modes; a table of sweeps gives the expected results.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       f_in;
  logic [3:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_fail;

  int n_checks = 0;
  int n_errors = 0;
  int f_mode   = 0;
  logic golden;

  truth_table_sweeper #(
    .N_IN   (4),
    .EXPECT (16'h0054),
    .SETTLE (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .f_in       (f_in),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circuit under test: golden f = ~a & ~d & (b | c), plus faulty variants.
  always_comb begin
    golden = ~vec[3] & ~vec[0] & (vec[2] | vec[1]);
    case (f_mode)
      1: f_in = 1'b0;
      2: f_in = 1'b1;
      3: f_in = ~golden;
      4: f_in = golden ^ (vec == 4'd9);
      5: f_in = golden ^ ((vec == 4'd6) || (vec == 4'd15));
      default: f_in = golden;
    endcase
  end

  typedef struct {
    int    mode;
    int    exp_err;
    int    exp_ff;
    int    exp_pass;
    bit    inject;
    bit    fin_start;
    string nm;
  } sweep_t;

  sweep_t tbl[8];

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Run one sweep starting in the current (post-edge) cycle and check it.
  task automatic sweep(input sweep_t t);
    int cyc;
    bit seen;
    bit busy_bad;
    f_mode   = t.mode;
    start    = 1'b1;
    cyc      = 0;
    seen     = 1'b0;
    busy_bad = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = t.inject && (cyc == 10 || cyc == 40);
      if (done) seen = 1'b1;
      else if (!busy) busy_bad = 1'b1;
    end
    check({t.nm, " done_seen"}, int'(seen), 1);
    check({t.nm, " latency"}, cyc, 65);
    check({t.nm, " busy_during"}, int'(busy_bad), 0);
    check({t.nm, " err_count"}, int'(err_count), t.exp_err);
    check({t.nm, " first_fail"}, int'(first_fail), t.exp_ff);
    check({t.nm, " pass"}, int'(pass), t.exp_pass);
    check({t.nm, " busy_at_done"}, int'(busy), 0);
    check({t.nm, " vec_last"}, int'(vec), 15);
    if (t.fin_start) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({t.nm, " done_pulse"}, int'(done), 0);
    check({t.nm, " busy_after"}, int'(busy), 0);
    check({t.nm, " pass_held"}, int'(pass), t.exp_pass);
    check({t.nm, " err_held"}, int'(err_count), t.exp_err);
    if (t.fin_start) begin
      @(posedge clk);
      #1;
      check({t.nm, " fin_start_ignored"}, int'(busy), 0);
    end
  endtask

  initial begin
    tbl[0] = '{0,  0, 0, 1, 1'b0, 1'b0, "T1_golden"};
    tbl[1] = '{1,  3, 2, 0, 1'b0, 1'b0, "T2_tie0"};
    tbl[2] = '{2, 13, 0, 0, 1'b0, 1'b1, "T3_tie1"};
    tbl[3] = '{3, 16, 0, 0, 1'b0, 1'b0, "T6_inverted"};
    tbl[4] = '{4,  1, 9, 0, 1'b0, 1'b0, "single_fault_9"};
    tbl[5] = '{5,  2, 6, 0, 1'b0, 1'b0, "faults_6_15"};
    tbl[6] = '{0,  0, 0, 1, 1'b1, 1'b0, "T5_ignore_start"};
    tbl[7] = '{0,  0, 0, 1, 1'b0, 1'b0, "T5_back_to_back"};

    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("reset vec", int'(vec), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset pass", int'(pass), 0);
    check("reset err_count", int'(err_count), 0);
    check("reset first_fail", int'(first_fail), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sweeps run back to back: each starts in the cycle after the previous
    // one returned to IDLE.
    for (int i = 0; i < 8; i++) begin
      sweep(tbl[i]);
    end

    // Reset 30 cycles into a failing sweep clears everything at once.
    f_mode = 1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    check("T4 busy_before_reset", int'(busy), 1);
    check("T4 err_before_reset", int'(err_count), 3);
    rst_n = 1'b0;
    #1;
    check("T4 reset vec", int'(vec), 0);
    check("T4 reset busy", int'(busy), 0);
    check("T4 reset done", int'(done), 0);
    check("T4 reset pass", int'(pass), 0);
    check("T4 reset err_count", int'(err_count), 0);
    check("T4 reset first_fail", int'(first_fail), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
